if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 169 ++++++++++++++++
 tb/tb_if_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles a 32-bit instruction from four byte reads,
// predicts JAL / backward branches as taken and presents the word to IF/ID.
module if_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_sign,
   input  logic        br_flag,
   input  logic [31:0] br_target,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_din,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_taken,
   output logic        stallreq_if
);

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_LAST = 2'd1,
      READY     = 2'd2
   } state_t;

   state_t      state_r, state_nx_s;
   logic [31:0] pc_r, pc_nx_s;
   logic [31:0] word_r, word_nx_s;
   logic [2:0]  issue_cnt_r, issue_nx_s;
   logic [2:0]  recv_cnt_r, recv_nx_s;
   logic        pending_r, issued_s;
   logic        taken_s;
   logic [31:0] next_pc_s;
   logic        stall_unused_s;

   assign stall_unused_s = ^{stall_sign[5:2], stall_sign[0]};

   function automatic logic [31:0] j_imm(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] b_imm(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   // Static prediction of the assembled word
   always_comb begin
      taken_s   = 1'b0;
      next_pc_s = pc_r + 32'd4;
      case (word_r[6:0])
         7'b1101111: begin
            taken_s   = 1'b1;
            next_pc_s = pc_r + j_imm(word_r);
         end
         7'b1100011: begin
            if (word_r[31]) begin
               taken_s   = 1'b1;
               next_pc_s = pc_r + b_imm(word_r);
            end else begin
               taken_s   = 1'b0;
               next_pc_s = pc_r + 32'd4;
            end
         end
         default: begin
            taken_s   = 1'b0;
            next_pc_s = pc_r + 32'd4;
         end
      endcase
   end

   // Next-state, byte assembly and output decode
   always_comb begin
      state_nx_s  = state_r;
      pc_nx_s     = pc_r;
      word_nx_s   = word_r;
      issue_nx_s  = issue_cnt_r;
      recv_nx_s   = recv_cnt_r;
      issued_s    = 1'b0;
      mem_req     = 1'b0;
      mem_addr    = pc_r + {29'd0, issue_cnt_r};
      if_pc       = 32'd0;
      if_inst     = 32'd0;
      if_taken    = 1'b0;
      stallreq_if = 1'b1;
      if (rst) begin
         state_nx_s = FETCH;
      end else if (br_flag) begin
         // Redirect wins: a byte landing now belongs to the squashed fetch
         state_nx_s = FETCH;
         pc_nx_s    = br_target;
         issue_nx_s = 3'd0;
         recv_nx_s  = 3'd0;
      end else begin
         if (pending_r) begin
            case (recv_cnt_r)
               3'd0:    word_nx_s[7:0]   = mem_din;
               3'd1:    word_nx_s[15:8]  = mem_din;
               3'd2:    word_nx_s[23:16] = mem_din;
               3'd3:    word_nx_s[31:24] = mem_din;
               default: word_nx_s        = word_r;
            endcase
            recv_nx_s = recv_cnt_r + 3'd1;
         end else begin
            recv_nx_s = recv_cnt_r;
         end
         case (state_r)
            FETCH: begin
               mem_req  = (issue_cnt_r < 3'd4);
               issued_s = mem_req & mem_gnt;
               if (issued_s) begin
                  issue_nx_s = issue_cnt_r + 3'd1;
                  if (issue_cnt_r == 3'd3) begin
                     state_nx_s = WAIT_LAST;
                  end else begin
                     state_nx_s = FETCH;
                  end
               end else begin
                  issue_nx_s = issue_cnt_r;
               end
            end
            WAIT_LAST: begin
               if (pending_r && (recv_cnt_r == 3'd3)) begin
                  state_nx_s = READY;
               end else begin
                  state_nx_s = WAIT_LAST;
               end
            end
            READY: begin
               if_pc       = pc_r;
               if_inst     = word_r;
               if_taken    = taken_s;
               stallreq_if = 1'b0;
               if (!stall_sign[1]) begin
                  pc_nx_s    = next_pc_s;
                  state_nx_s = FETCH;
                  issue_nx_s = 3'd0;
                  recv_nx_s  = 3'd0;
               end else begin
                  state_nx_s = READY;
               end
            end
            default: begin
               state_nx_s = FETCH;
               issue_nx_s = 3'd0;
               recv_nx_s  = 3'd0;
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= FETCH;
         pc_r        <= 32'd0;
         word_r      <= 32'd0;
         issue_cnt_r <= 3'd0;
         recv_cnt_r  <= 3'd0;
         pending_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         pc_r        <= pc_nx_s;
         word_r      <= word_nx_s;
         issue_cnt_r <= issue_nx_s;
         recv_cnt_r  <= recv_nx_s;
         pending_r   <= issued_s;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: acts as byte memory and checks every cycle against a
// transaction-level model of the fetch stage; directed cases then random traffic.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall_sign = 6'd0;
   logic        br_flag = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        mem_gnt = 1'b0;
   logic [7:0]  mem_din = 8'd0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_taken;
   logic        stallreq_if;

   if_fetch dut (
      .clk(clk), .rst(rst), .stall_sign(stall_sign), .br_flag(br_flag),
      .br_target(br_target), .mem_gnt(mem_gnt), .mem_din(mem_din),
      .mem_req(mem_req), .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst),
      .if_taken(if_taken), .stallreq_if(stallreq_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [logic [31:0]];
   logic [7:0]  din_next = 8'd0;
   logic [31:0] m_pc = 32'd0;
   int          m_iss = 0;
   int          m_rcv = 0;
   bit          m_arr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] h;
      if (mem.exists(a)) return mem[a];
      h = a * 32'h9E3779B1;
      return h[23:16];
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
   endfunction

   task automatic put_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
   endtask

   // Reference prediction built from signed field weights
   task automatic predict(input logic [31:0] pc, input logic [31:0] w,
                          output logic tk, output logic [31:0] npc);
      int imm;
      tk  = 1'b0;
      imm = 4;
      if (w[6:0] == 7'h6F) begin
         tk  = 1'b1;
         imm = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
               + int'(w[30:21]) * 2;
      end else if (w[6:0] == 7'h63 && w[31]) begin
         tk  = 1'b1;
         imm = -4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      npc = pc + 32'(imm);
   endtask

   task automatic bubble_chk(input string tag);
      chk({tag, "_stall"}, {31'd0, stallreq_if}, 32'd1);
      chk({tag, "_pc"}, if_pc, 32'd0);
      chk({tag, "_inst"}, if_inst, 32'd0);
      chk({tag, "_taken"}, {31'd0, if_taken}, 32'd0);
   endtask

   // One clock: drive at negedge, check settled outputs, advance the model
   task automatic cycle(input logic r, input logic [5:0] st, input logic bf,
                        input logic [31:0] bt, input logic g);
      logic        tk;
      logic [31:0] npc;
      @(negedge clk);
      rst = r; stall_sign = st; br_flag = bf; br_target = bt; mem_gnt = g;
      mem_din = din_next;
      #1;
      din_next = 8'($urandom);
      if (r) begin
         bubble_chk("rst");
         chk("rst_req", {31'd0, mem_req}, 32'd0);
         m_pc = 32'd0; m_iss = 0; m_rcv = 0; m_arr = 1'b0;
      end else if (bf) begin
         bubble_chk("br");
         chk("br_req", {31'd0, mem_req}, 32'd0);
         m_pc = bt; m_iss = 0; m_rcv = 0; m_arr = 1'b0;
      end else if (m_rcv == 4) begin
         predict(m_pc, word_at(m_pc), tk, npc);
         chk("rdy_stall", {31'd0, stallreq_if}, 32'd0);
         chk("rdy_pc", if_pc, m_pc);
         chk("rdy_inst", if_inst, word_at(m_pc));
         chk("rdy_taken", {31'd0, if_taken}, {31'd0, tk});
         chk("rdy_req", {31'd0, mem_req}, 32'd0);
         if (!st[1]) begin
            m_pc = npc; m_iss = 0; m_rcv = 0;
         end
         m_arr = 1'b0;
      end else begin
         bubble_chk("busy");
         chk("busy_req", {31'd0, mem_req}, (m_iss < 4) ? 32'd1 : 32'd0);
         if (m_iss < 4) chk("busy_addr", mem_addr, m_pc + 32'(m_iss));
         if (m_arr) m_rcv++;
         m_arr = (m_iss < 4) && g;
         if (m_arr) m_iss++;
         if (mem_req && g) din_next = byte_at(mem_addr);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40 && stallreq_if; i++) cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      chk("ready_timeout", {31'd0, stallreq_if}, 32'd0);
   endtask

   task automatic consume_then_peek(input string tag, input logic [31:0] exp_addr);
      cycle(1'b0, 6'h00, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b0);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
   endtask

   initial begin
      logic [5:0] gpat;
      logic [5:0] st;
      put_word(32'h0, 32'h00100513);
      put_word(32'h10, 32'h0080006F);
      put_word(32'h20, 32'hFE000EE3);
      put_word(32'h1C, 32'h00000463);
      put_word(32'hFFFFFFFC, 32'h00000013);

      cycle(1'b1, 6'h02, 1'b0, 32'd0, 1'b1);
      cycle(1'b1, 6'h02, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      chk("first_stall", {31'd0, stallreq_if}, 32'd0);
      chk("first_inst", if_inst, 32'h00100513);
      chk("first_pc", if_pc, 32'd0);
      chk("first_taken", {31'd0, if_taken}, 32'd0);

      cycle(1'b0, 6'h02, 1'b1, 32'h10, 1'b1);
      wait_ready();
      chk("jal_taken", {31'd0, if_taken}, 32'd1);
      consume_then_peek("jal_next", 32'h18);

      cycle(1'b0, 6'h02, 1'b1, 32'h20, 1'b1);
      wait_ready();
      chk("beq_back_taken", {31'd0, if_taken}, 32'd1);
      consume_then_peek("beq_back_next", 32'h1C);
      wait_ready();
      chk("beq_fwd_taken", {31'd0, if_taken}, 32'd0);
      consume_then_peek("beq_fwd_next", 32'h20);

      cycle(1'b0, 6'h02, 1'b1, 32'h40, 1'b0);
      gpat = 6'b111001;
      for (int i = 0; i < 6; i++) cycle(1'b0, 6'h02, 1'b0, 32'd0, gpat[i]);
      wait_ready();
      chk("gnt_toggle_inst", if_inst, word_at(32'h40));

      cycle(1'b0, 6'h02, 1'b1, 32'h80, 1'b0);
      cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 6'h02, 1'b1, 32'h100, 1'b1);
      cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
      chk("redir_addr", mem_addr, 32'h100);
      wait_ready();
      chk("redir_inst", if_inst, word_at(32'h100));
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 6'h02, 1'b0, 32'd0, 1'b1);
         chk("hold_inst", if_inst, word_at(32'h100));
         chk("hold_pc", if_pc, 32'h100);
      end

      cycle(1'b0, 6'h02, 1'b1, 32'hFFFFFFFC, 1'b1);
      wait_ready();
      chk("wrap_pc", if_pc, 32'hFFFFFFFC);
      consume_then_peek("wrap_next", 32'h0);

      for (int i = 0; i < 3000; i++) begin
         st    = 6'($urandom);
         st[1] = ($urandom_range(0, 9) < 3);
         cycle(($urandom_range(0, 199) == 0), st, ($urandom_range(0, 29) == 0),
               $urandom, ($urandom_range(0, 9) < 7));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
